// File: rtl/turf_tally.sv
// End-of-round territory counter: sweeps the 160x120 occupancy RAM once per start,
// tallies pixels per player owner code and reports totals, winner and tie.
module turf_tally #(
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120,
  parameter int CNT_W = 15
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start,
  output logic [14:0]      ram_address,
  input  logic [2:0]       ram_q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] p1_count,
  output logic [CNT_W-1:0] p2_count,
  output logic [CNT_W-1:0] p3_count,
  output logic [CNT_W-1:0] p4_count,
  output logic [1:0]       winner,
  output logic             tie
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_RESULT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_x;
  logic [6:0]       r_y;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt [4];
  logic [1:0]       r_winner;
  logic             r_tie;

  logic             w_last;
  logic             w_y_wrap;
  logic             w_hit;
  logic [1:0]       w_idx;
  logic [1:0]       w_win;
  logic [CNT_W-1:0] w_max;
  logic             w_tie;

  assign w_last   = (r_x == 8'(X_MAX - 1)) && (r_y == 7'(Y_MAX - 1));
  assign w_y_wrap = (r_y == 7'(Y_MAX - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SCAN;
      S_SCAN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_RESULT;
      S_RESULT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_hit = 1'b1;
    w_idx = 2'd0;
    case (ram_q)
      3'b001:  w_idx = 2'd0;
      3'b010:  w_idx = 2'd1;
      3'b100:  w_idx = 2'd2;
      3'b110:  w_idx = 2'd3;
      default: w_hit = 1'b0;
    endcase
  end

  // Strict '>' keeps the lowest index on equal counts; all-zero yields winner 0 with tie.
  always_comb begin
    w_win = 2'd0;
    w_max = r_cnt[0];
    for (int unsigned i = 1; i < 4; i++) begin
      if (r_cnt[i] > w_max) begin
        w_max = r_cnt[i];
        w_win = 2'(i);
      end
    end
    w_tie = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((2'(i) != w_win) && (r_cnt[i] == w_max)) w_tie = 1'b1;
    end
  end

  // r_valid marks the cycle in which ram_q belongs to the address driven one cycle earlier.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_x      <= '0;
      r_y      <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_winner <= '0;
      r_tie    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_valid <= (r_state == S_SCAN);
      r_done  <= 1'b0;
      if (r_valid && w_hit) r_cnt[w_idx] <= r_cnt[w_idx] + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy   <= 1'b1;
            r_x      <= '0;
            r_y      <= '0;
            r_winner <= '0;
            r_tie    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
          end
        end
        S_SCAN: begin
          if (!w_last) begin
            if (w_y_wrap) begin
              r_y <= '0;
              r_x <= r_x + 8'd1;
            end else begin
              r_y <= r_y + 7'd1;
            end
          end
        end
        S_RESULT: begin
          r_winner <= w_win;
          r_tie    <= w_tie;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ram_address = {r_x, r_y};
  assign busy        = r_busy;
  assign done        = r_done;
  assign p1_count    = r_cnt[0];
  assign p2_count    = r_cnt[1];
  assign p3_count    = r_cnt[2];
  assign p4_count    = r_cnt[3];
  assign winner      = r_winner;
  assign tie         = r_tie;

endmodule
